// File: rtl/led_pixel_rx.sv
// WS2812-style pixel node: decodes the NRZ line by high-pulse width, keeps the first
// BITS_PER_LED bits, forwards later bits (3-clk latency) and latches on a line-reset gap.
module led_pixel_rx #(
   parameter int BITS_PER_LED = 24,
   parameter int T_GLITCH     = 10,
   parameter int T_BIT_THRESH = 60,
   parameter int T_HIGH_MAX   = 150,
   parameter int T_RESET      = 5000,
   parameter int CNT_W        = $clog2(T_RESET + 1)
) (
   input  logic                    i_clk,
   input  logic                    i_rst_n,
   input  logic                    i_serial,
   output logic                    o_serial,
   output logic [BITS_PER_LED-1:0] o_led,
   output logic                    o_latch,
   output logic                    o_frame_err
);
   localparam int BC_W = $clog2(BITS_PER_LED + 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = '1;
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] GLITCH_C = CNT_W'(T_GLITCH);
   localparam logic [CNT_W-1:0] THRESH_C = CNT_W'(T_BIT_THRESH);
   localparam logic [CNT_W-1:0] HMAX_C   = CNT_W'(T_HIGH_MAX);
   localparam logic [CNT_W-1:0] RESET_C  = CNT_W'(T_RESET);
   localparam logic [BC_W-1:0]  BITS_C   = BC_W'(BITS_PER_LED);

   typedef enum logic [1:0] {IDLE, HIGH, LOW, ERR} state_t;

   state_t                  state_q, state_d;
   logic                    sync1_q, s_ser;
   logic [CNT_W-1:0]        hi_cnt_q, hi_cnt_d;
   logic [CNT_W-1:0]        lo_cnt_q, lo_cnt_d;
   logic [BC_W-1:0]         bit_cnt_q, bit_cnt_d;
   logic [BITS_PER_LED-1:0] shift_q, shift_d;
   logic [BITS_PER_LED-1:0] led_q, led_d;
   logic                    fwd_q, fwd_d;
   logic                    ser_q, ser_d;
   logic                    latch_q, latch_d;
   logic                    ferr_q, ferr_d;
   logic                    bit_vld, bit_val, gap_hit;

   always_comb begin
      state_d   = state_q;
      hi_cnt_d  = hi_cnt_q;
      lo_cnt_d  = lo_cnt_q;
      bit_cnt_d = bit_cnt_q;
      shift_d   = shift_q;
      led_d     = led_q;
      fwd_d     = fwd_q;
      latch_d   = 1'b0;
      ferr_d    = 1'b0;
      bit_vld   = 1'b0;
      bit_val   = 1'b0;
      gap_hit   = 1'b0;

      case (state_q)
         IDLE, LOW: begin
            if (s_ser) begin
               state_d  = HIGH;
               hi_cnt_d = CNT_ONE;
            end else begin
               if (lo_cnt_q != CNT_MAX) lo_cnt_d = lo_cnt_q + 1'b1;
               gap_hit = (lo_cnt_q == RESET_C);
            end
         end
         HIGH: begin
            if (!s_ser) begin
               // Glitches leave the low counter frozen so the gap keeps timing.
               state_d = LOW;
               if (hi_cnt_q >= GLITCH_C) begin
                  bit_vld  = 1'b1;
                  bit_val  = (hi_cnt_q >= THRESH_C);
                  lo_cnt_d = CNT_ONE;
               end
            end else if (hi_cnt_q > HMAX_C) begin
               state_d  = ERR;
               ferr_d   = 1'b1;
               lo_cnt_d = '0;
            end else if (hi_cnt_q != CNT_MAX) begin
               hi_cnt_d = hi_cnt_q + 1'b1;
            end
         end
         default: begin
            if (s_ser) begin
               lo_cnt_d = '0;
            end else begin
               if (lo_cnt_q != CNT_MAX) lo_cnt_d = lo_cnt_q + 1'b1;
               gap_hit = (lo_cnt_q == RESET_C);
            end
         end
      endcase

      if (bit_vld && (bit_cnt_q < BITS_C)) begin
         shift_d   = {shift_q[BITS_PER_LED-2:0], bit_val};
         bit_cnt_d = bit_cnt_q + 1'b1;
         if (bit_cnt_q == BITS_C - 1'b1) fwd_d = 1'b1;
      end

      if (gap_hit) begin
         if (bit_cnt_q == BITS_C) begin
            led_d   = shift_q;
            latch_d = 1'b1;
         end else if (bit_cnt_q != '0) begin
            ferr_d = 1'b1;
         end
         bit_cnt_d = '0;
         fwd_d     = 1'b0;
         state_d   = IDLE;
      end

      ser_d = fwd_q & s_ser & (state_d != ERR);
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q   <= IDLE;
         sync1_q   <= 1'b0;
         s_ser     <= 1'b0;
         hi_cnt_q  <= '0;
         lo_cnt_q  <= '0;
         bit_cnt_q <= '0;
         shift_q   <= '0;
         led_q     <= '0;
         fwd_q     <= 1'b0;
         ser_q     <= 1'b0;
         latch_q   <= 1'b0;
         ferr_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         sync1_q   <= i_serial;
         s_ser     <= sync1_q;
         hi_cnt_q  <= hi_cnt_d;
         lo_cnt_q  <= lo_cnt_d;
         bit_cnt_q <= bit_cnt_d;
         shift_q   <= shift_d;
         led_q     <= led_d;
         fwd_q     <= fwd_d;
         ser_q     <= ser_d;
         latch_q   <= latch_d;
         ferr_q    <= ferr_d;
      end
   end

   assign o_serial    = ser_q;
   assign o_led       = led_q;
   assign o_latch     = latch_q;
   assign o_frame_err = ferr_q;
endmodule

// File: tb/tb_led_pixel_rx.sv
// Bench for led_pixel_rx: pulse-width stimulus, frame-level decode model and an
// output monitor that decodes the forwarded stream.
module tb_led_pixel_rx;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        ser_in = 1'b0;
   logic        o_serial;
   logic [23:0] o_led;
   logic        o_latch;
   logic        o_frame_err;

   int errors = 0;
   int checks = 0;

   int latch_cnt = 0, ferr_cnt = 0, both_cnt = 0, ser_hi_cnt = 0, ser_w = 0;
   logic [23:0] last_led = '0;
   bit fwd_q[$];

   int hw_q[$];
   logic [23:0] m_led = '0;
   bit m_latch;
   int m_ferr;
   bit m_fwd[$];

   led_pixel_rx dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_serial(ser_in),
      .o_serial(o_serial), .o_led(o_led), .o_latch(o_latch), .o_frame_err(o_frame_err)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (o_latch) begin
         latch_cnt++;
         last_led = o_led;
      end
      if (o_frame_err) ferr_cnt++;
      if (o_latch && o_frame_err) both_cnt++;
      if (o_serial) begin
         ser_hi_cnt++;
         ser_w++;
      end else if (ser_w > 0) begin
         fwd_q.push_back(ser_w >= 60);
         ser_w = 0;
      end
   end

   task automatic drive(input bit v, input int n);
      ser_in = v;
      repeat (n) @(negedge clk);
   endtask

   task automatic pulse(input int h, input int l);
      drive(1'b1, h);
      drive(1'b0, l);
      hw_q.push_back(h);
   endtask

   task automatic send_word(input logic [63:0] d, input int n, input bit fast);
      for (int i = n - 1; i >= 0; i--) begin
         bit b = d[i];
         if (fast) pulse(b ? $urandom_range(110, 62) : $urandom_range(45, 12), $urandom_range(25, 10));
         else      pulse(b ? 80 : 40, b ? 45 : 85);
      end
   endtask

   task automatic gap();
      drive(1'b0, 5010);
   endtask

   // Frame-level reference: drop sub-10 pulses, stop at a >150 pulse, keep 24 bits, forward the rest.
   task automatic model_frame();
      int n = 0;
      bit err = 0;
      logic [23:0] w = '0;
      m_fwd.delete();
      m_ferr = 0;
      m_latch = 0;
      foreach (hw_q[i]) begin
         if (err || hw_q[i] < 10) continue;
         if (hw_q[i] > 150) begin
            err = 1;
            m_ferr++;
         end else if (n < 24) begin
            w = {w[22:0], hw_q[i] >= 60};
            n++;
         end else begin
            m_fwd.push_back(hw_q[i] >= 60);
         end
      end
      if (n == 24) begin
         m_latch = 1;
         m_led = w;
      end else if (n > 0) begin
         m_ferr++;
      end
      hw_q.delete();
   endtask

   function automatic logic [63:0] pack_bits(input bit q[$], input int start);
      logic [63:0] v = '0;
      for (int i = start; i < q.size(); i++) v = {v[62:0], q[i]};
      return v;
   endfunction

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      checks++; if (o_led !== 24'h0) begin errors++; $display("FAIL reset_led: got %h want 000000", o_led); end
      checks++; if (o_serial !== 1'b0) begin errors++; $display("FAIL reset_serial: got %b want 0", o_serial); end
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      checks++; if (o_latch !== 1'b0) begin errors++; $display("FAIL reset_latch: got %b want 0", o_latch); end
      checks++; if (o_frame_err !== 1'b0) begin errors++; $display("FAIL reset_ferr: got %b want 0", o_frame_err); end
      m_led = '0;
   endtask

   task automatic test_basic();
      int l0 = latch_cnt, f0 = ferr_cnt, s0 = ser_hi_cnt;
      send_word(64'hFF00FF, 24, 0);
      gap();
      model_frame();
      checks++; if (latch_cnt - l0 !== 1) begin errors++; $display("FAIL basic_latch_cnt: got %0d want 1", latch_cnt - l0); end
      checks++; if (o_led !== 24'hFF00FF) begin errors++; $display("FAIL basic_led: got %h want ff00ff", o_led); end
      checks++; if (ser_hi_cnt - s0 !== 0) begin errors++; $display("FAIL basic_serial_quiet: got %0d high cycles want 0", ser_hi_cnt - s0); end
      checks++; if (ferr_cnt - f0 !== 0) begin errors++; $display("FAIL basic_ferr: got %0d want 0", ferr_cnt - f0); end
   endtask

   task automatic test_forward();
      int l0 = latch_cnt, q0 = fwd_q.size();
      send_word(64'h123456ABCDEF, 48, 0);
      gap();
      model_frame();
      checks++; if (latch_cnt - l0 !== 1) begin errors++; $display("FAIL fwd_latch_cnt: got %0d want 1", latch_cnt - l0); end
      checks++; if (o_led !== 24'h123456) begin errors++; $display("FAIL fwd_led: got %h want 123456", o_led); end
      checks++; if (fwd_q.size() - q0 !== 24) begin errors++; $display("FAIL fwd_count: got %0d want 24", fwd_q.size() - q0); end
      checks++; if (pack_bits(fwd_q, q0) !== 64'hABCDEF) begin errors++; $display("FAIL fwd_data: got %h want abcdef", pack_bits(fwd_q, q0)); end
   endtask

   task automatic test_random();
      for (int it = 0; it < 2; it++) begin
         int l0 = latch_cnt, q0 = fwd_q.size();
         int extra = (it == 0) ? 0 : $urandom_range(24, 1);
         logic [63:0] d = {$urandom, $urandom};
         send_word(d, 24 + extra, 1);
         gap();
         model_frame();
         checks++; if (latch_cnt - l0 !== int'(m_latch)) begin errors++; $display("FAIL rand_latch_cnt: got %0d want %0d", latch_cnt - l0, m_latch); end
         checks++; if (o_led !== m_led) begin errors++; $display("FAIL rand_led: got %h want %h", o_led, m_led); end
         checks++; if (pack_bits(fwd_q, q0) !== pack_bits(m_fwd, 0) || fwd_q.size() - q0 !== m_fwd.size())
            begin errors++; $display("FAIL rand_fwd: got %h/%0d want %h/%0d", pack_bits(fwd_q, q0), fwd_q.size() - q0, pack_bits(m_fwd, 0), m_fwd.size()); end
      end
   endtask

   task automatic test_partial();
      int l0 = latch_cnt, f0 = ferr_cnt;
      send_word({$urandom, $urandom}, 12, 1);
      gap();
      model_frame();
      checks++; if (ferr_cnt - f0 !== m_ferr) begin errors++; $display("FAIL partial_ferr: got %0d want %0d", ferr_cnt - f0, m_ferr); end
      checks++; if (latch_cnt - l0 !== 0) begin errors++; $display("FAIL partial_no_latch: got %0d want 0", latch_cnt - l0); end
      checks++; if (o_led !== m_led) begin errors++; $display("FAIL partial_led_kept: got %h want %h", o_led, m_led); end
      l0 = latch_cnt;
      send_word({$urandom, $urandom}, 24, 1);
      gap();
      model_frame();
      checks++; if (latch_cnt - l0 !== 1) begin errors++; $display("FAIL partial_next_latch: got %0d want 1", latch_cnt - l0); end
      checks++; if (o_led !== m_led) begin errors++; $display("FAIL partial_next_led: got %h want %h", o_led, m_led); end
   endtask

   task automatic test_glitch();
      logic [23:0] d = 24'hA5A5A5;
      for (int f = 0; f < 2; f++) begin
         int l0 = latch_cnt;
         if (f == 1) d = $urandom;
         for (int i = 23; i >= 0; i--) begin
            if (f == 0) pulse(d[i] ? 60 : 59, 20);
            else        pulse(d[i] ? $urandom_range(100, 62) : 10, 20);
            pulse((f == 0) ? 5 : 9, 20);
         end
         gap();
         model_frame();
         checks++; if (latch_cnt - l0 !== 1) begin errors++; $display("FAIL glitch_latch_cnt: got %0d want 1", latch_cnt - l0); end
         checks++; if (o_led !== m_led || o_led !== d) begin errors++; $display("FAIL glitch_led: got %h want %h", o_led, d); end
      end
   endtask

   task automatic test_stuck_high();
      int l0 = latch_cnt, f0 = ferr_cnt, s0 = ser_hi_cnt;
      send_word({$urandom, $urandom}, 10, 1);
      pulse(200, 20);
      send_word({$urandom, $urandom}, 20, 1);
      gap();
      model_frame();
      checks++; if (ferr_cnt - f0 !== m_ferr) begin errors++; $display("FAIL stuck_ferr: got %0d want %0d", ferr_cnt - f0, m_ferr); end
      checks++; if (latch_cnt - l0 !== 0) begin errors++; $display("FAIL stuck_no_latch: got %0d want 0", latch_cnt - l0); end
      checks++; if (ser_hi_cnt - s0 !== 0) begin errors++; $display("FAIL stuck_serial_quiet: got %0d want 0", ser_hi_cnt - s0); end
      l0 = latch_cnt;
      send_word({$urandom, $urandom}, 24, 1);
      gap();
      model_frame();
      checks++; if (latch_cnt - l0 !== 1) begin errors++; $display("FAIL stuck_recover_latch: got %0d want 1", latch_cnt - l0); end
      checks++; if (o_led !== m_led) begin errors++; $display("FAIL stuck_recover_led: got %h want %h", o_led, m_led); end
   endtask

   task automatic test_mid_reset();
      int l0, f0;
      send_word({$urandom, $urandom}, 10, 1);
      rst_n = 1'b0;
      hw_q.delete();
      m_led = '0;
      @(negedge clk);
      checks++; if (o_led !== 24'h0) begin errors++; $display("FAIL midrst_led_clear: got %h want 000000", o_led); end
      rst_n = 1'b1;
      drive(1'b0, 20);
      l0 = latch_cnt;
      f0 = ferr_cnt;
      send_word(64'h00FF00, 24, 1);
      gap();
      model_frame();
      checks++; if (o_led !== 24'h00FF00) begin errors++; $display("FAIL midrst_led: got %h want 00ff00", o_led); end
      checks++; if (ferr_cnt - f0 !== 0) begin errors++; $display("FAIL midrst_ferr: got %0d want 0", ferr_cnt - f0); end
      checks++; if (latch_cnt - l0 !== 1) begin errors++; $display("FAIL midrst_latch_cnt: got %0d want 1", latch_cnt - l0); end
   endtask

   initial begin
      @(negedge clk);
      test_reset();
      test_basic();
      test_forward();
      test_random();
      test_partial();
      test_glitch();
      test_stuck_high();
      test_mid_reset();
      checks++; if (both_cnt !== 0) begin errors++; $display("FAIL latch_ferr_overlap: got %0d cycles want 0", both_cnt); end
      checks++; if (last_led !== m_led) begin errors++; $display("FAIL last_latched: got %h want %h", last_led, m_led); end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
